// File: rtl/tb_mux_pkg.sv
// ---------------------------------------------------------------------------
// tb_mux_pkg
//   Shared constants and the round-robin pick function for the 8:1 funnel
//   that sits in front of mux8.
//
//   NUM_REQ : requester count (fixed at 8)
//   SEL_W   : width of the mux8 select / requester index
//   rr_pick : given a request vector and the current highest-priority
//             index, returns {found, idx}. idx is the first requester at or
//             after ptr (mod 8) with a request; when nothing is requesting,
//             found=0 and idx=ptr, so the select holds steady.
// ---------------------------------------------------------------------------
package tb_mux_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
//   Pure combinational round-robin picker: rotates the request vector so
//   that ptr lands at bit 0, finds the lowest set bit, and maps it back to
//   an absolute requester index.
//
//   req   in  [7:0]  request vector
//   ptr   in  [2:0]  highest-priority index
//   found out        at least one request is present
//   win   out [2:0]  winning index; equals ptr when found=0
// ---------------------------------------------------------------------------
module rr_pick8
    import tb_mux_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   win
);

    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;

    // rot[k] is the request of the requester k places after ptr.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            rot[k] = req[ptr + SEL_W'(k)];
        end
    end

    // Find-first from bit 0; scanning downwards lets the lowest hit win.
    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SEL_W'(k);
            end
        end
    end

    assign found = |req;
    assign win   = ptr + off;  // off=0 when idle, so win falls back to ptr

endmodule

// File: rtl/rr_arb8_stage.sv
// ---------------------------------------------------------------------------
// rr_arb8_stage
//   Round-robin arbiter plus registered output stage upstream of mux8.
//   The arbiter drives mux8's select; mux8's word comes back on mux_data and
//   is captured into a valid/ready output register tagged with its source.
//
//   clk        in               rising-edge clock
//   rst        in               synchronous active-high reset
//   req        in  [7:0]        per-requester request (not latched here)
//   gnt        out [7:0]        one-hot grant, only in the accept cycle
//   sel        out [2:0]        select to mux8
//   mux_data   in  [DW-1:0]     mux8 output for the current sel
//   out_valid  out              output register holds a word
//   out_ready  in               downstream takes out_data this cycle
//   out_data   out [DW-1:0]     captured word
//   out_src    out [2:0]        requester index that produced out_data
//
//   Handshake: a word moves downstream on any edge where out_valid and
//   out_ready are both high; while out_valid=1 and out_ready=0 the output
//   (out_valid, out_data, out_src) is frozen. A requester is served on the
//   edge after its gnt bit is high and must drop or advance req next cycle.
// ---------------------------------------------------------------------------
module rr_arb8_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [$clog2(NUM_REQ)-1:0]  sel,
    input  logic [DATA_WIDTH-1:0]       mux_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [$clog2(NUM_REQ)-1:0]  out_src
);

    import tb_mux_pkg::SEL_W;

    if (NUM_REQ != 8) begin : g_bad_num_req
        $error("rr_arb8_stage: NUM_REQ must be 8");
    end

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] win;
    logic             found;
    logic             accept;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .win   (win)
    );

    // A new word may enter when the register is empty or being drained in
    // the same cycle; this is what gives one word per cycle at full rate.
    assign accept = found & (~out_valid | out_ready) & ~rst;

    // sel keeps tracking the winner even during a stall so mux8 settles.
    assign sel = win;

    always_comb begin
        gnt = '0;
        if (accept) begin
            gnt[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (accept) begin
            out_data  <= mux_data;
            out_src   <= win;
            out_valid <= 1'b1;
            ptr       <= win + 1'b1;  // 7 wraps to 0 in 3 bits
        end else if (out_valid && out_ready) begin
            // Drained with nothing to replace it; data/src keep stale values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb8_stage.sv
// ---------------------------------------------------------------------------
// tb_rr_arb8_stage
//   Directed bench for rr_arb8_stage with a behavioural mux8 in front of it.
// ---------------------------------------------------------------------------
module tb_rr_arb8_stage;
    import tb_mux_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic [31:0] mux_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_src;

    logic [31:0] in_data [8];

    int checks = 0;
    int errors = 0;

    rr_arb8_stage #(.DATA_WIDTH(32), .NUM_REQ(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .mux_data  (mux_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    // mux8 stand-in: combinational 8:1 select.
    assign mux_data = in_data[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) in_data[i] = 32'hA0 + i;
        rst       = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b1;

        // Reset held for two edges with everyone requesting.
        tick();
        chk("rst1_gnt", gnt, 0);
        chk("rst1_valid", out_valid, 0);
        chk("rst1_data", out_data, 0);
        chk("rst1_src", out_src, 0);
        tick();
        chk("rst2_gnt", gnt, 0);
        chk("rst2_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        chk("rel_gnt", gnt, 8'h01);
        chk("rel_sel", sel, 0);

        // Full rotation: 9 accepts, 0..7 then 0.
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("rot%0d_gnt", i), gnt, 8'h01 << (i % 8));
            tick();
            chk($sformatf("rot%0d_valid", i), out_valid, 1);
            chk($sformatf("rot%0d_src", i), out_src, i % 8);
            chk($sformatf("rot%0d_data", i), out_data, 32'hA0 + (i % 8));
        end
        // ptr is now 1

        // Sparse plus wrap: grant 5 first so ptr becomes 6.
        req = 8'h20;
        #1;
        chk("sp_g5_gnt", gnt, 8'h20);
        tick();
        chk("sp_g5_src", out_src, 5);
        req = 8'b0010_0001;
        #1;
        chk("sp_wrap_model", {28'd0, rr_pick(8'b0010_0001, 3'd6)}, {28'd0, 4'b1000});
        chk("sp_wrap_gnt", gnt, 8'h01);
        chk("sp_wrap_sel", sel, 0);
        tick();
        chk("sp_wrap_src", out_src, 0);
        chk("sp_wrap_data", out_data, 32'hA0);
        #1;
        chk("sp_next_gnt", gnt, 8'h20);
        chk("sp_next_sel", sel, 5);
        tick();
        chk("sp_next_src", out_src, 5);
        chk("sp_next_data", out_data, 32'hA5);
        // ptr is now 6

        // Backpressure: capture requester 2, then stall three cycles while
        // mux8 presents a different word for index 2.
        req = 8'h04;
        #1;
        chk("bp_cap_gnt", gnt, 8'h04);
        tick();
        chk("bp_cap_src", out_src, 2);
        chk("bp_cap_data", out_data, 32'hA2);
        out_ready   = 1'b0;
        in_data[2]  = 32'hDEAD_0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_gnt", i), gnt, 0);
            chk($sformatf("bp%0d_sel", i), sel, 2);
            tick();
            chk($sformatf("bp%0d_valid", i), out_valid, 1);
            chk($sformatf("bp%0d_data", i), out_data, 32'hA2);
            chk($sformatf("bp%0d_src", i), out_src, 2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_gnt", gnt, 8'h04);
        tick();
        chk("bp_rel_valid", out_valid, 1);
        chk("bp_rel_data", out_data, 32'hDEAD_0002);
        chk("bp_rel_src", out_src, 2);
        in_data[2] = 32'hA2;
        // ptr is now 3

        // Idle drain: single pulse on req[3], then nothing.
        req = 8'h08;
        #1;
        chk("id_gnt", gnt, 8'h08);
        tick();
        chk("id_src", out_src, 3);
        chk("id_valid", out_valid, 1);
        req = 8'h00;
        #1;
        chk("id_idle_gnt", gnt, 0);
        chk("id_idle_sel", sel, 4);
        tick();
        chk("id_drain_valid", out_valid, 0);
        chk("id_drain_src", out_src, 3);
        chk("id_drain_data", out_data, 32'hA3);
        tick();
        chk("id_idle2_valid", out_valid, 0);
        chk("id_idle2_sel", sel, 4);
        chk("id_idle2_gnt", gnt, 0);

        // Reset mid-stall discards the held word.
        req = 8'h02;
        #1;
        chk("rs_gnt", gnt, 8'h02);
        tick();
        chk("rs_src", out_src, 1);
        chk("rs_data", out_data, 32'hA1);
        out_ready = 1'b0;
        #1;
        chk("rs_stall_gnt", gnt, 0);
        tick();
        chk("rs_stall_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rs_rst_gnt", gnt, 0);
        tick();
        chk("rs_after_valid", out_valid, 0);
        chk("rs_after_data", out_data, 0);
        chk("rs_after_src", out_src, 0);
        rst = 1'b0;
        req = 8'h00;
        #1;
        chk("rs_ptr_sel", sel, 0);
        req = 8'h80;
        #1;
        chk("rs_g7_gnt", gnt, 8'h80);
        req = 8'hFF;
        #1;
        chk("rs_ptr0_gnt", gnt, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
